// File: rtl/fdivsqrt_seq_if.sv
// Request and done handshakes between the issue stage, the divide/sqrt
// sequencer, and the postprocessing/writeback consumer.
interface fdivsqrt_seq_if #(
  parameter int NBW = 8
);
  logic           ReqValid;
  logic           ReqReady;
  logic           SqrtIn;
  logic           SpecialCaseIn;
  logic [NBW-1:0] NumBits;
  logic           DoneValid;
  logic           DoneReady;
  logic           DoneSpecial;

  modport master (
    output ReqValid, SqrtIn, SpecialCaseIn, NumBits, DoneReady,
    input  ReqReady, DoneValid, DoneSpecial
  );

  modport slave (
    input  ReqValid, SqrtIn, SpecialCaseIn, NumBits, DoneReady,
    output ReqReady, DoneValid, DoneSpecial
  );
endinterface

// File: rtl/fdivsqrt_seq.sv
// Divide/sqrt iteration sequencer: start strobe, exact iteration count,
// frozen result with done handshake, special-case bypass and flush abort.
module fdivsqrt_seq #(
  parameter  int DIVb      = 64,
  parameter  int DIVCOPIES = 2,
  parameter  int RADIX     = 4,
  parameter  int NBW       = 8,
  localparam int LOGR      = (RADIX == 4) ? 2 : 1,
  localparam int B         = LOGR * DIVCOPIES,
  localparam int MAXC      = ((1 << NBW) - 1 + B - 1) / B,
  localparam int ILW       = $clog2(MAXC) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  fdivsqrt_seq_if.slave    io,
  input  logic             FlushE,
  output logic             IFDivStartE,
  output logic             FDivBusyE,
  output logic             SqrtE,
  output logic [ILW-1:0]   IterLeft
);

  if (!(RADIX == 2 || RADIX == 4) || DIVb < 1 || DIVCOPIES < 1) begin : g_bad_cfg
    $error("fdivsqrt_seq: illegal RADIX/DIVCOPIES/DIVb");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = NBW + 1;

  state_t         state, state_n;
  logic [ILW-1:0] iter_n, cycles;
  logic [CW-1:0]  nb_rnd;
  logic           sqrt_n, special_q, special_n, accept;

  // ceil(NumBits/B) against a constant divisor; zero bits still takes one cycle
  assign nb_rnd = {1'b0, io.NumBits} + CW'(B - 1);
  assign cycles = (io.NumBits == '0) ? ILW'(1) : ILW'(nb_rnd / CW'(B));

  assign io.ReqReady    = (state == IDLE) & ~FlushE;
  assign accept         = io.ReqValid & io.ReqReady;
  assign io.DoneValid   = (state == DONE) & ~FlushE;
  assign io.DoneSpecial = special_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      IterLeft  <= '0;
      SqrtE     <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state     <= state_n;
      IterLeft  <= iter_n;
      SqrtE     <= sqrt_n;
      special_q <= special_n;
    end
  end

  always_comb begin
    state_n     = state;
    iter_n      = IterLeft;
    sqrt_n      = SqrtE;
    special_n   = special_q;
    IFDivStartE = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        sqrt_n = io.SqrtIn;
        if (io.SpecialCaseIn) begin
          special_n = 1'b1;
          state_n   = DONE;
        end else begin
          IFDivStartE = 1'b1;
          iter_n      = cycles;
          state_n     = BUSY;
        end
      end
      BUSY: if (FlushE) begin
        iter_n  = '0;
        state_n = IDLE;
      end else begin
        iter_n = IterLeft - ILW'(1);
        if (IterLeft == ILW'(1)) state_n = DONE;
      end
      DONE: if (FlushE || io.DoneReady) begin
        special_n = 1'b0;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // a flush in BUSY must not clock the iteration registers again
    FDivBusyE = IFDivStartE | ((state == BUSY) & ~FlushE);
  end

endmodule
